// File: rtl/pulse_timestamper.sv
// pulse_timestamper: measures envelope pulses on four sensors against a 24-bit timestamp
// and emits one packed 48-bit word per in-window pulse through a round-robin arbiter.
module pulse_timestamper #(
  parameter int MIN_WIDTH = 2,
  parameter int MAX_WIDTH = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  envelope_n,
  output logic        out_valid,
  output logic [47:0] out_data,
  output logic [7:0]  overflow_count
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;
  logic [3:0]  sync_q, e_s_q;
  logic [23:0] ts_q, ts_d;
  state_t      state_q [4], state_d [4];
  logic [23:0] start_q [4], start_d [4];
  logic [15:0] width_q [4], width_d [4];
  logic [3:0]  slot_full_q, slot_full_d;
  logic [15:0] slot_width_q [4], slot_width_d [4];
  logic [23:0] slot_start_q [4], slot_start_d [4];
  logic [1:0]  ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [47:0] out_data_q, out_data_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [3:0]  offer, grant, load;
  logic        found;
  logic [1:0]  gidx, idx;
  logic [2:0]  drops;
  logic [8:0]  ovf_sum;

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign overflow_count = ovf_q;

  always_comb begin
    ts_d    = ts_q + 24'd1;
    state_d = state_q;
    start_d = start_q;
    width_d = width_q;
    offer   = '0;
    for (int i = 0; i < 4; i++) begin
      case (state_q[i])
        IDLE: if (!e_s_q[i]) begin
          state_d[i] = ACTIVE;
          start_d[i] = ts_q;
          width_d[i] = 16'd1;
        end
        ACTIVE: if (!e_s_q[i]) begin
          if (width_q[i] == 16'(MAX_WIDTH)) state_d[i] = DISCARD;
          else width_d[i] = width_q[i] + 16'd1;
        end else begin
          offer[i]   = width_q[i] >= 16'(MIN_WIDTH);
          state_d[i] = IDLE;
        end
        DISCARD: if (e_s_q[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Scan full slots starting at the pointer; first hit wins this cycle.
  always_comb begin
    found = 1'b0;
    gidx  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && slot_full_q[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant = '0;
    if (found) grant[gidx] = 1'b1;
    out_valid_d = found;
    out_data_d  = found ? {gidx, slot_width_q[gidx], 6'd0, slot_start_q[gidx]} : out_data_q;
    ptr_d       = found ? gidx + 2'd1 : ptr_q;
  end

  always_comb begin
    slot_width_d = slot_width_q;
    slot_start_d = slot_start_q;
    slot_full_d  = slot_full_q & ~grant;
    load         = '0;
    drops        = '0;
    for (int i = 0; i < 4; i++) begin
      load[i] = offer[i] && (!slot_full_q[i] || grant[i]);
      if (load[i]) begin
        slot_full_d[i]  = 1'b1;
        slot_width_d[i] = width_q[i];
        slot_start_d[i] = start_q[i];
      end
      drops = drops + {2'b0, offer[i] & ~load[i]};
    end
    ovf_sum = {1'b0, ovf_q} + {6'b0, drops};
    ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '1;
      e_s_q       <= '1;
      ts_q        <= '0;
      slot_full_q <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i]      <= IDLE;
        start_q[i]      <= '0;
        width_q[i]      <= '0;
        slot_width_q[i] <= '0;
        slot_start_q[i] <= '0;
      end
    end else begin
      sync_q       <= envelope_n;
      e_s_q        <= sync_q;
      ts_q         <= ts_d;
      state_q      <= state_d;
      start_q      <= start_d;
      width_q      <= width_d;
      slot_full_q  <= slot_full_d;
      slot_width_q <= slot_width_d;
      slot_start_q <= slot_start_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      ovf_q        <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pulse_timestamper.sv
// tb_pulse_timestamper: directed pulses with a scoreboard queue; a negedge monitor
// pops and compares every out_valid word.
module tb_pulse_timestamper;
  logic        clk = 0;
  logic        resetn = 0;
  logic [3:0]  envelope_n = 4'hF;
  logic        out_valid;
  logic [47:0] out_data;
  logic [7:0]  overflow_count;
  logic [47:0] q[$];
  logic [23:0] cyc, ts_off, st;
  int          checks = 0, errors = 0;

  pulse_timestamper dut (
    .clk(clk), .resetn(resetn), .envelope_n(envelope_n),
    .out_valid(out_valid), .out_data(out_data), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= '0;
    else cyc <= cyc + 24'd1;

  function automatic logic [47:0] word(input logic [1:0] s, input logic [15:0] w, input logic [23:0] t);
    return {s, w, 6'd0, t};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pins low from the next cycle for len cycles; returns the start the DUT should report.
  task automatic pulse(input logic [3:0] m, input int len, output logic [23:0] s);
    @(posedge clk); #1;
    s = cyc + ts_off + 24'd2;
    envelope_n = ~m;
    repeat (len) @(posedge clk);
    #1 envelope_n = 4'hF;
  endtask

  task automatic gap();
    repeat (12) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!resetn) chk("valid_in_reset", {47'd0, out_valid}, 48'd0);
    else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else chk("word", out_data, q.pop_front());
    end
  end

  initial begin
    ts_off = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    chk("rst_valid", {47'd0, out_valid}, 48'd0);
    chk("rst_data", out_data, 48'd0);
    chk("rst_ovf", {40'd0, overflow_count}, 48'd0);
    repeat (49) @(posedge clk);
    pulse(4'b0100, 100, st);
    q.push_back(word(2, 100, 24'd52));
    gap();
    pulse(4'b0001, 1, st);
    gap();
    pulse(4'b0001, 2, st);
    q.push_back(word(0, 2, st));
    gap();
    pulse(4'b0001, 1000, st);
    q.push_back(word(0, 1000, st));
    gap();
    pulse(4'b0001, 1001, st);
    gap();
    pulse(4'b0001, 5, st);
    q.push_back(word(0, 5, st));
    gap();
    pulse(4'b1000, 7, st);
    q.push_back(word(3, 7, st));
    gap();
    pulse(4'b1111, 20, st);
    for (int i = 0; i < 4; i++) q.push_back(word(2'(i), 20, st));
    gap();
    pulse(4'b0010, 4, st);
    q.push_back(word(1, 4, st));
    gap();
    pulse(4'b1001, 6, st);
    q.push_back(word(3, 6, st));
    q.push_back(word(0, 6, st));
    gap();
    @(posedge clk); #1;
    force dut.ts_q = 24'hFFFFFB;
    ts_off = 24'hFFFFFB - cyc;
    #1 release dut.ts_q;
    pulse(4'b0100, 10, st);
    q.push_back(word(2, 10, 24'hFFFFFE));
    gap();
    pulse(4'b0100, 3, st);
    q.push_back(word(2, 3, st));
    gap();
    chk("drained_before_reset", 48'(q.size()), 48'd0);
    @(posedge clk); #1 envelope_n[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1 resetn = 0;
    ts_off = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    chk("rel_valid", {47'd0, out_valid}, 48'd0);
    chk("rel_data", out_data, 48'd0);
    chk("rel_ovf", {40'd0, overflow_count}, 48'd0);
    repeat (27) @(posedge clk);
    #1 envelope_n = 4'hF;
    q.push_back(word(1, 27, 24'd2));
    repeat (20) @(posedge clk);
    chk("queue_empty", 48'(q.size()), 48'd0);
    chk("final_ovf", {40'd0, overflow_count}, 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
